// File: rtl/botassium_cpu_cpu_debug_mem_arbiter_if.sv
// Purpose : bundles the JTAG-action, Avalon debug_mem_slave and OCI RAM signals
//           of the debug-memory arbiter into one port.
// Latency : n/a (wiring only).
// Backpressure: Avalon side stalls on avs_waitrequest; JTAG side has no stall and
//           reports a dropped strobe through jtag_ovf.
//
// Modports:
//   slave  - the arbiter: consumes requests and RAM read data, drives responses
//            and the RAM command.
//   master - the surroundings (JTAG decode, Avalon master, RAM).
interface botassium_cpu_cpu_debug_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // JTAG action side
    logic              jtag_req;
    logic              jtag_write;
    logic [ADDR_W-1:0] jtag_addr;
    logic [DATA_W-1:0] jtag_wdata;
    logic [DATA_W-1:0] jtag_rdata;
    logic              jtag_done;
    logic              jtag_ovf;
    logic              jtag_ovf_clr;

    // Avalon debug_mem_slave side
    logic              avs_read;
    logic              avs_write;
    logic [ADDR_W-1:0] avs_address;
    logic [DATA_W-1:0] avs_writedata;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_waitrequest;

    // OCI RAM side (registered read data, one cycle latency)
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  jtag_req, jtag_write, jtag_addr, jtag_wdata, jtag_ovf_clr,
        output jtag_rdata, jtag_done, jtag_ovf,
        input  avs_read, avs_write, avs_address, avs_writedata,
        output avs_readdata, avs_waitrequest,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata
    );

    modport master (
        output jtag_req, jtag_write, jtag_addr, jtag_wdata, jtag_ovf_clr,
        input  jtag_rdata, jtag_done, jtag_ovf,
        output avs_read, avs_write, avs_address, avs_writedata,
        input  avs_readdata, avs_waitrequest,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );
endinterface

// File: rtl/botassium_cpu_cpu_debug_mem_arbiter.sv
// Purpose : shares the single-port OCI debug RAM between JTAG action strobes and
//           the CPU-side Avalon debug_mem_slave, with CPU starvation protection.
// Latency : every access is 2 RAM cycles (ACC, CMP); JTAG strobe -> grant >= 1
//           cycle, jtag_done 2 cycles after grant; idle Avalon command completes
//           (waitrequest low) on its 3rd cycle.
// Backpressure: Avalon is stalled via avs_waitrequest until its CMP cycle; JTAG
//           cannot be stalled - a strobe arriving while one is still pending and
//           not being granted is dropped and flagged in sticky jtag_ovf.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - slave modport: jtag_* (strobe/response), avs_* (Avalon slave),
//              ram_* (RAM command out, registered read data in)
module botassium_cpu_cpu_debug_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    botassium_cpu_cpu_debug_mem_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        J_ACC = 3'd1,
        J_CMP = 3'd2,
        A_ACC = 3'd3,
        A_CMP = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // JTAG holding register: one request deep
    logic              jtag_pend;
    logic              hold_write;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_wdata;

    // Remembers whether the JTAG access in flight is a write, so J_CMP knows
    // whether to capture read data. The holding register may already contain
    // the next request by then, so it cannot be used for this.
    logic              jtag_acc_write;

    logic [CNT_W-1:0]  starve_cnt;

    logic              avs_req;
    logic              avs_req_arb;
    logic              arb_state;
    logic              starved;
    logic              grant_j;
    logic              grant_a;
    logic              ovf_set;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    assign avs_req   = bus.avs_read | bus.avs_write;
    // In A_CMP the Avalon command on the bus is the one completing this very
    // cycle; it must not be granted a second time.
    assign avs_req_arb = avs_req && (state != A_CMP);
    assign arb_state   = (state == IDLE) || (state == J_CMP) || (state == A_CMP);
    assign starved     = (starve_cnt == STARVE_LIM);

    assign grant_j = arb_state && (state_nxt == J_ACC);
    assign grant_a = arb_state && (state_nxt == A_ACC);

    // A second strobe is only absorbed if the pending one leaves the holding
    // register at the same edge.
    assign ovf_set = bus.jtag_req && jtag_pend && !grant_j;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = IDLE;
        case (state)
            J_ACC: state_nxt = J_CMP;
            A_ACC: state_nxt = A_CMP;
            default: begin
                // IDLE, J_CMP, A_CMP all arbitrate, allowing back-to-back grants
                if (jtag_pend && avs_req_arb && starved) begin
                    state_nxt = A_ACC;
                end else if (jtag_pend) begin
                    state_nxt = J_ACC;
                end else if (avs_req_arb) begin
                    state_nxt = A_ACC;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.jtag_done       = (state == J_CMP);
        bus.avs_waitrequest = (state != A_CMP);
    end

    // RAM read data is registered by the RAM itself and valid in A_CMP
    assign bus.avs_readdata = bus.ram_rdata;

    // ------------------------------------------------------------------
    // JTAG capture and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_pend  <= 1'b0;
            hold_write <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else if (bus.jtag_req && (!jtag_pend || grant_j)) begin
            jtag_pend  <= 1'b1;
            hold_write <= bus.jtag_write;
            hold_addr  <= bus.jtag_addr;
            hold_wdata <= bus.jtag_wdata;
        end else if (grant_j) begin
            jtag_pend  <= 1'b0;
        end
    end

    // A new drop in the same cycle as a clear wins, so it is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.jtag_ovf <= 1'b0;
        end else if (ovf_set) begin
            bus.jtag_ovf <= 1'b1;
        end else if (bus.jtag_ovf_clr) begin
            bus.jtag_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: consecutive JTAG grants while Avalon is waiting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!avs_req || grant_a) begin
            starve_cnt <= '0;
        end else if (grant_j && avs_req_arb && !starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // RAM command: loaded on the grant edge so it is stable for the whole ACC
    // cycle; address/data hold afterwards, write enable only lives in ACC.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            bus.ram_we     <= 1'b0;
            jtag_acc_write <= 1'b0;
        end else if (grant_j) begin
            bus.ram_addr   <= hold_addr;
            bus.ram_wdata  <= hold_wdata;
            bus.ram_we     <= hold_write;
            jtag_acc_write <= hold_write;
        end else if (grant_a) begin
            // a write asserted together with a read is treated as a write
            bus.ram_addr   <= bus.avs_address;
            bus.ram_wdata  <= bus.avs_writedata;
            bus.ram_we     <= bus.avs_write;
        end else begin
            bus.ram_we     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // JTAG read data capture (feeds MonDReg)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.jtag_rdata <= '0;
        end else if ((state == J_CMP) && !jtag_acc_write) begin
            bus.jtag_rdata <= bus.ram_rdata;
        end
    end

endmodule

// File: tb/tb_botassium_cpu_cpu_debug_mem_arbiter.sv
module tb_botassium_cpu_cpu_debug_mem_arbiter;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    botassium_cpu_cpu_debug_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    botassium_cpu_cpu_debug_mem_arbiter #(
        .ADDR_W(8), .DATA_W(32), .STARVE_MAX(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM model with registered read data
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic idle_inputs();
        bus.jtag_req      = 1'b0;
        bus.jtag_write    = 1'b0;
        bus.jtag_addr     = 8'h00;
        bus.jtag_wdata    = 32'h0;
        bus.jtag_ovf_clr  = 1'b0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_address   = 8'h00;
        bus.avs_writedata = 32'h0;
    endtask

    task automatic jtag_strobe(input logic wr, input logic [7:0] a, input logic [31:0] d);
        bus.jtag_req   = 1'b1;
        bus.jtag_write = wr;
        bus.jtag_addr  = a;
        bus.jtag_wdata = d;
    endtask

    // Complete uncontended JTAG access; starts/ends just after a negedge with FSM idle.
    task automatic jtag_access(input logic wr, input logic [7:0] a, input logic [31:0] d);
        jtag_strobe(wr, a, d);
        @(negedge clk);
        bus.jtag_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL rst_waitreq: got %0b want 1", bus.avs_waitrequest); end
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_bad++; $display("FAIL rst_ram_we: got %0b want 0", bus.ram_we); end
        n_cmp++; if (bus.jtag_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %0b want 0", bus.jtag_done); end
        n_cmp++; if (bus.jtag_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %0b want 0", bus.jtag_ovf); end
        n_cmp++; if (bus.jtag_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %0h want 0", bus.jtag_rdata); end
        n_cmp++; if (bus.ram_addr !== 8'h00) begin n_bad++; $display("FAIL rst_ram_addr: got %0h want 0", bus.ram_addr); end
    endtask

    task automatic test_jtag_write_read();
        jtag_strobe(1'b1, 8'h10, 32'hDEADBEEF);
        @(negedge clk);                                   // pend set, still IDLE
        bus.jtag_req = 1'b0;
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_bad++; $display("FAIL jw_we_early: got %0b want 0", bus.ram_we); end
        @(negedge clk);                                   // J_ACC
        n_cmp++; if (bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL jw_we: got %0b want 1", bus.ram_we); end
        n_cmp++; if (bus.ram_addr !== 8'h10) begin n_bad++; $display("FAIL jw_addr: got %0h want 10", bus.ram_addr); end
        n_cmp++; if (bus.ram_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL jw_wdata: got %0h want deadbeef", bus.ram_wdata); end
        n_cmp++; if (bus.jtag_done !== 1'b0) begin n_bad++; $display("FAIL jw_done_early: got %0b want 0", bus.jtag_done); end
        @(negedge clk);                                   // J_CMP
        n_cmp++; if (bus.jtag_done !== 1'b1) begin n_bad++; $display("FAIL jw_done: got %0b want 1", bus.jtag_done); end
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_bad++; $display("FAIL jw_we_drop: got %0b want 0", bus.ram_we); end
        @(negedge clk);                                   // IDLE
        n_cmp++; if (bus.jtag_done !== 1'b0) begin n_bad++; $display("FAIL jw_done_pulse: got %0b want 0", bus.jtag_done); end
        jtag_strobe(1'b0, 8'h10, 32'h0);
        @(negedge clk);
        bus.jtag_req = 1'b0;
        @(negedge clk);                                   // J_ACC (read)
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_bad++; $display("FAIL jr_we: got %0b want 0", bus.ram_we); end
        @(negedge clk);                                   // J_CMP
        n_cmp++; if (bus.jtag_done !== 1'b1) begin n_bad++; $display("FAIL jr_done: got %0b want 1", bus.jtag_done); end
        @(negedge clk);
        n_cmp++; if (bus.jtag_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL jr_rdata: got %0h want deadbeef", bus.jtag_rdata); end
    endtask

    task automatic test_avalon_read();
        jtag_access(1'b1, 8'h20, 32'h12345678);
        bus.avs_read    = 1'b1;                           // cycle 1: IDLE
        bus.avs_address = 8'h20;
        n_cmp++; if (bus.avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL ar_wait1: got %0b want 1", bus.avs_waitrequest); end
        @(negedge clk);                                   // cycle 2: A_ACC
        n_cmp++; if (bus.avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL ar_wait2: got %0b want 1", bus.avs_waitrequest); end
        n_cmp++; if (bus.ram_addr !== 8'h20) begin n_bad++; $display("FAIL ar_addr: got %0h want 20", bus.ram_addr); end
        @(negedge clk);                                   // cycle 3: A_CMP
        n_cmp++; if (bus.avs_waitrequest !== 1'b0) begin n_bad++; $display("FAIL ar_wait3: got %0b want 0", bus.avs_waitrequest); end
        n_cmp++; if (bus.avs_readdata !== 32'h12345678) begin n_bad++; $display("FAIL ar_data: got %0h want 12345678", bus.avs_readdata); end
        n_cmp++; if (bus.jtag_done !== 1'b0) begin n_bad++; $display("FAIL ar_no_done: got %0b want 0", bus.jtag_done); end
        bus.avs_read = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL ar_wait4: got %0b want 1", bus.avs_waitrequest); end
    endtask

    task automatic test_contention();
        jtag_strobe(1'b0, 8'h10, 32'h0);                  // keep FSM busy
        @(negedge clk);
        bus.jtag_req = 1'b0;
        @(negedge clk);                                   // J_ACC: both request in the same cycle
        jtag_strobe(1'b1, 8'h30, 32'hA5A5A5A5);
        bus.avs_write     = 1'b1;
        bus.avs_address   = 8'h31;
        bus.avs_writedata = 32'h0BADF00D;
        @(negedge clk);                                   // J_CMP of the first access
        bus.jtag_req = 1'b0;
        n_cmp++; if (bus.avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL ct_wait_a: got %0b want 1", bus.avs_waitrequest); end
        @(negedge clk);                                   // JTAG wins
        n_cmp++; if (bus.ram_addr !== 8'h30 || bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL ct_j_first: got addr %0h we %0b want 30/1", bus.ram_addr, bus.ram_we); end
        @(negedge clk);                                   // J_CMP
        n_cmp++; if (bus.jtag_done !== 1'b1 || bus.avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL ct_j_cmp: got done %0b wait %0b want 1/1", bus.jtag_done, bus.avs_waitrequest); end
        @(negedge clk);                                   // A_ACC granted from J_CMP
        n_cmp++; if (bus.ram_addr !== 8'h31 || bus.ram_we !== 1'b1 || bus.ram_wdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL ct_a_acc: got addr %0h we %0b data %0h want 31/1/badf00d", bus.ram_addr, bus.ram_we, bus.ram_wdata); end
        @(negedge clk);                                   // A_CMP
        n_cmp++; if (bus.avs_waitrequest !== 1'b0) begin n_bad++; $display("FAIL ct_wait_low: got %0b want 0", bus.avs_waitrequest); end
        bus.avs_write = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL ct_wait_once: got %0b want 1", bus.avs_waitrequest); end
        jtag_access(1'b0, 8'h31, 32'h0);
        n_cmp++; if (bus.jtag_rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL ct_a_landed: got %0h want badf00d", bus.jtag_rdata); end
        jtag_access(1'b0, 8'h30, 32'h0);
        n_cmp++; if (bus.jtag_rdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL ct_j_landed: got %0h want a5a5a5a5", bus.jtag_rdata); end
    endtask

    task automatic test_starvation();
        int done_cnt = 0;
        int done_before = -1;
        logic avs_seen = 1'b0;
        logic [31:0] rd = 32'h0;
        bus.avs_address = 8'h20;
        for (int c = 0; c < 24; c++) begin
            if (bus.jtag_done === 1'b1) done_cnt++;
            if (bus.avs_waitrequest === 1'b0 && !avs_seen) begin
                avs_seen    = 1'b1;
                done_before = done_cnt;
                rd          = bus.avs_readdata;
            end
            bus.jtag_req   = (c <= 8) && (c % 2 == 0);
            bus.jtag_write = 1'b0;
            bus.jtag_addr  = 8'h10;
            bus.avs_read   = (c >= 1) && !avs_seen;
            @(negedge clk);
        end
        n_cmp++; if (avs_seen !== 1'b1) begin n_bad++; $display("FAIL st_avs_done: got %0b want 1 within 24 cycles", avs_seen); end
        n_cmp++; if (done_before != 4) begin n_bad++; $display("FAIL st_grants: got %0d want 4", done_before); end
        n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL st_data: got %0h want 12345678", rd); end
        n_cmp++; if (done_cnt != 5) begin n_bad++; $display("FAIL st_total: got %0d want 5", done_cnt); end
        n_cmp++; if (dut.starve_cnt !== 3'd0) begin n_bad++; $display("FAIL st_cnt: got %0d want 0", dut.starve_cnt); end
        n_cmp++; if (bus.jtag_ovf !== 1'b0) begin n_bad++; $display("FAIL st_ovf: got %0b want 0", bus.jtag_ovf); end
    endtask

    task automatic test_overflow();
        bus.avs_read    = 1'b1;                           // IDLE: Avalon wins (pend still 0)
        bus.avs_address = 8'h20;
        jtag_strobe(1'b1, 8'h50, 32'h11111111);
        @(negedge clk);                                   // A_ACC, pend=1, no grant
        n_cmp++; if (bus.jtag_ovf !== 1'b0) begin n_bad++; $display("FAIL ov_early: got %0b want 0", bus.jtag_ovf); end
        jtag_strobe(1'b1, 8'h50, 32'h22222222);
        @(negedge clk);                                   // A_CMP
        n_cmp++; if (bus.jtag_ovf !== 1'b1) begin n_bad++; $display("FAIL ov_set: got %0b want 1", bus.jtag_ovf); end
        n_cmp++; if (bus.avs_waitrequest !== 1'b0) begin n_bad++; $display("FAIL ov_wait: got %0b want 0", bus.avs_waitrequest); end
        bus.jtag_req = 1'b0;
        bus.avs_read = 1'b0;
        @(negedge clk);                                   // J_ACC for the first strobe
        n_cmp++; if (bus.ram_wdata !== 32'h11111111) begin n_bad++; $display("FAIL ov_kept: got %0h want 11111111", bus.ram_wdata); end
        @(negedge clk);
        n_cmp++; if (bus.jtag_ovf !== 1'b1) begin n_bad++; $display("FAIL ov_sticky: got %0b want 1", bus.jtag_ovf); end
        bus.jtag_ovf_clr = 1'b1;
        @(negedge clk);
        bus.jtag_ovf_clr = 1'b0;
        n_cmp++; if (bus.jtag_ovf !== 1'b0) begin n_bad++; $display("FAIL ov_clr: got %0b want 0", bus.jtag_ovf); end
        jtag_access(1'b0, 8'h50, 32'h0);
        n_cmp++; if (bus.jtag_rdata !== 32'h11111111) begin n_bad++; $display("FAIL ov_mem: got %0h want 11111111", bus.jtag_rdata); end
    endtask

    task automatic test_reset_mid();
        int low_cnt = 0;
        bus.avs_write     = 1'b1;
        bus.avs_address   = 8'h60;
        bus.avs_writedata = 32'hFFFFFFFF;
        @(negedge clk);                                   // A_ACC
        n_cmp++; if (bus.ram_we !== 1'b1) begin n_bad++; $display("FAIL rm_we_on: got %0b want 1", bus.ram_we); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_bad++; $display("FAIL rm_we_drop: got %0b want 0", bus.ram_we); end
        bus.avs_write = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.avs_waitrequest === 1'b0) low_cnt++;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.avs_waitrequest === 1'b0) low_cnt++;
        end
        n_cmp++; if (low_cnt != 0) begin n_bad++; $display("FAIL rm_no_ack: got %0d low cycles want 0", low_cnt); end
        n_cmp++; if (bus.jtag_rdata !== 32'h0) begin n_bad++; $display("FAIL rm_rdata: got %0h want 0", bus.jtag_rdata); end
        // FSM must be back in IDLE: a fresh read completes on its 3rd cycle
        bus.avs_read    = 1'b1;
        bus.avs_address = 8'h20;
        @(negedge clk);
        n_cmp++; if (bus.avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL rm_idle2: got %0b want 1", bus.avs_waitrequest); end
        @(negedge clk);
        n_cmp++; if (bus.avs_waitrequest !== 1'b0 || bus.avs_readdata !== 32'h12345678) begin n_bad++; $display("FAIL rm_idle3: got wait %0b data %0h want 0/12345678", bus.avs_waitrequest, bus.avs_readdata); end
        bus.avs_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_jtag_write_read();
        test_avalon_read();
        test_contention();
        test_starvation();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
